// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch / sequencing path.
// START_ADDR holds the entry point of each of the four selectable programs.
package fetch_pkg;

    localparam int PC_W        = 10;
    localparam int OFF_W       = 8;
    localparam int INSTR_W     = 9;
    localparam int OPCODE_W    = 3;
    localparam int REG_FIELD_W = 3;
    localparam int IMM_FIELD_W = 3;
    localparam int CNT_W       = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam logic [PC_W-1:0] START_ADDR [4] = '{10'd0, 10'd128, 10'd256, 10'd384};

endpackage

// File: rtl/fetch_sequencer_next_pc.sv
// next_pc_calc: combinational next-PC selection (hold, sequential, or taken branch).
// Arithmetic wraps modulo 2^PC_W; the offset is sign-extended, so -1 taken spins in place.
module next_pc_calc
    import fetch_pkg::*;
(
    input  logic [PC_W-1:0]  pc,
    input  logic             branch_en,
    input  logic             flag_hit,
    input  logic [OFF_W-1:0] branch_off,
    input  logic             stall,
    output logic [PC_W-1:0]  next_pc
);

    logic [PC_W-1:0] seq_pc;
    logic [PC_W-1:0] off_ext;

    assign seq_pc  = pc + {{(PC_W-1){1'b0}}, 1'b1};
    assign off_ext = {{(PC_W-OFF_W){branch_off[OFF_W-1]}}, branch_off};

    // Stall holds, a taken branch is relative to the following instruction
    always_comb begin
        next_pc = seq_pc;
        if (stall) begin
            next_pc = pc;
        end else if (branch_en && flag_hit) begin
            next_pc = seq_pc + off_ext;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, runs the req/run/ack handshake and gates the instruction word.
// Optional executed-instruction counter enabled by defining FETCH_CYCLE_COUNT_EN.
//
// state | meaning
// IDLE  | out of reset, waiting for the first req
// RUN   | fetching one instruction per cycle
// HALT  | program finished, ack high until the next req restarts
module fetch_sequencer
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               req,
    input  logic [1:0]         prog_sel,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               stall,
    input  logic               branch_en,
    input  logic               flag_hit,
    input  logic [OFF_W-1:0]   branch_off,
    input  logic               halt,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] instr,
    output logic               run,
    output logic               ack,
    output logic [CNT_W-1:0]   cycle_cnt
);

    fetch_state_t    state_q;
    fetch_state_t    state_d;
    logic [PC_W-1:0] next_pc;
    logic            start_load;
    logic            pc_adv;

    next_pc_calc u_next_pc (
        .pc         (pc),
        .branch_en  (branch_en),
        .flag_hit   (flag_hit),
        .branch_off (branch_off),
        .stall      (stall),
        .next_pc    (next_pc)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: req is only honoured outside RUN, halt ends a program
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req)  state_d = RUN;
            RUN:     if (halt) state_d = HALT;
            HALT:    if (req)  state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs and PC control strobes decoded from the current state
    always_comb begin
        run        = (state_q == RUN);
        ack        = (state_q == HALT);
        start_load = (state_q != RUN) && req;
        pc_adv     = (state_q == RUN) && !halt;
    end

    // Program counter: load entry point on start, otherwise follow next_pc while running
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= '0;
        end else if (start_load) begin
            pc <= START_ADDR[prog_sel];
        end else if (pc_adv) begin
            pc <= next_pc;
        end
    end

    assign instr = run ? instr_in : '0;

`ifdef FETCH_CYCLE_COUNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Count executed instructions (halting one included), saturating, cleared on start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (start_load) begin
            cnt_q <= '0;
        end else if (run && (halt || !stall) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign cycle_cnt = cnt_q;
`else
    assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed walk through the sequencing cases
// followed by randomized cycles, all compared against a behavioural model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [1:0]  prog_sel;
    logic [8:0]  instr_in;
    logic        stall;
    logic        branch_en;
    logic        flag_hit;
    logic [7:0]  branch_off;
    logic        halt;
    logic [9:0]  pc;
    logic [8:0]  instr;
    logic        run;
    logic        ack;
    logic [15:0] cycle_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // model state: mode 0 = idle, 1 = running, 2 = halted
    int m_pc   = 0;
    int m_mode = 0;
    int m_cnt  = 0;
    int starts [4] = '{0, 128, 256, 384};

    fetch_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .prog_sel   (prog_sel),
        .instr_in   (instr_in),
        .stall      (stall),
        .branch_en  (branch_en),
        .flag_hit   (flag_hit),
        .branch_off (branch_off),
        .halt       (halt),
        .pc         (pc),
        .instr      (instr),
        .run        (run),
        .ack        (ack),
        .cycle_cnt  (cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int cnt_exp();
`ifdef FETCH_CYCLE_COUNT_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".pc"}, int'(pc), m_pc);
        chk({tag, ".run"}, int'(run), (m_mode == 1) ? 1 : 0);
        chk({tag, ".ack"}, int'(ack), (m_mode == 2) ? 1 : 0);
        chk({tag, ".instr"}, int'(instr), (m_mode == 1) ? int'(instr_in) : 0);
        chk({tag, ".cnt"}, int'(cycle_cnt), cnt_exp());
    endtask

    // one clock cycle: apply inputs, advance the model by the sequencing rules, compare
    task automatic step(input bit r, input int ps, input bit st, input bit be,
                        input bit fh, input int off, input bit h, input string tag);
        int soff;
        req        = r;
        prog_sel   = 2'(ps);
        stall      = st;
        branch_en  = be;
        flag_hit   = fh;
        branch_off = 8'(off);
        halt       = h;
        instr_in   = 9'($urandom_range(511));
        soff = int'($signed(8'(off)));
        @(posedge clk);
        if (m_mode != 1) begin
            if (r) begin
                m_pc   = starts[ps];
                m_mode = 1;
                m_cnt  = 0;
            end
        end else if (h) begin
            m_mode = 2;
            if (m_cnt < 65535) m_cnt++;
        end else if (!st) begin
            if (m_cnt < 65535) m_cnt++;
            if (be && fh) m_pc = ((m_pc + 1 + soff) % 1024 + 1024) % 1024;
            else          m_pc = (m_pc + 1) % 1024;
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic seq(input string tag);
        step(0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    task automatic take(input int off, input string tag);
        step(0, 0, 0, 1, 1, off, 0, tag);
    endtask

    initial begin
        reset = 1'b1; req = 0; prog_sel = 0; instr_in = 9'h1AB;
        stall = 0; branch_en = 0; flag_hit = 0; branch_off = 0; halt = 0;
        @(posedge clk); #1;
        check_outputs("reset");
        reset = 1'b0;
        seq("idle_hold");

        // start program 1 and walk sequentially
        step(1, 1, 0, 0, 0, 0, 0, "start1");
        chk("start1_pc_lit", int'(pc), 128);
        seq("seq129");
        seq("seq130");
        chk("seq_pc_lit", int'(pc), 130);
        step(1, 3, 0, 0, 0, 0, 0, "req_in_run_ignored");

        // reach 200, then not-taken and taken negative branch
        take(68, "to200");
        chk("at200", int'(pc), 200);
        step(0, 0, 0, 1, 0, -10, 0, "not_taken");
        chk("not_taken_lit", int'(pc), 201);
        take(-2, "back200");
        take(-10, "neg10");
        chk("neg10_lit", int'(pc), 191);
        take(-1, "spin");
        chk("spin_lit", int'(pc), 191);
        step(0, 0, 1, 1, 1, 40, 0, "stall_beats_branch");

        // halt, restart on program 3, climb to 1023 and wrap
        step(0, 0, 0, 0, 0, 0, 1, "halt1");
        step(1, 3, 0, 0, 0, 0, 0, "start3");
        for (int i = 0; i < 4; i++) take(127, "climb");
        take(126, "to1023");
        chk("at1023", int'(pc), 1023);
        seq("wrap0");
        chk("wrap0_lit", int'(pc), 0);
        take(-5, "to1020");
        chk("at1020", int'(pc), 1020);
        take(5, "wrap_branch");
        chk("wrap_branch_lit", int'(pc), 2);

        // halt + stall + taken branch together at 50
        take(47, "to50");
        step(0, 0, 1, 1, 1, 20, 1, "halt_prio");
        chk("halt_prio_pc", int'(pc), 50);
        chk("halt_prio_ack", int'(ack), 1);
        seq("halt_hold");
        step(1, 2, 0, 0, 0, 0, 0, "restart2");
        chk("restart2_pc", int'(pc), 256);
        chk("restart2_ack", int'(ack), 0);

        // 20 instructions, three stalled, last one halts
        for (int i = 0; i < 20; i++)
            step(0, 0, (i == 3 || i == 7 || i == 11), 0, 0, 0, (i == 19), "count_run");
`ifdef FETCH_CYCLE_COUNT_EN
        chk("count17", int'(cycle_cnt), 17);
`endif
        chk("count_halt_pc", int'(pc), 272);
        seq("count_hold1");
        step(0, 1, 1, 1, 1, 3, 1, "count_hold2");
        step(1, 2, 0, 0, 0, 0, 0, "count_clear");
        for (int i = 0; i < 44; i++) seq("to300");
        chk("at300", int'(pc), 300);

        // asynchronous reset mid-program, req ignored while reset held
        #3;
        reset = 1'b1;
        m_pc = 0; m_mode = 0; m_cnt = 0;
        #1;
        check_outputs("async_reset");
        req = 1'b1; prog_sel = 2'd3;
        @(posedge clk); #1;
        check_outputs("req_in_reset");
        reset = 1'b0;
        seq("post_reset_idle");

        // randomized cycles, including occasional restarts from HALT
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(5) == 0), int'($urandom_range(3)),
                 ($urandom_range(3) == 0), bit'($urandom_range(1)),
                 bit'($urandom_range(1)), int'($urandom_range(255)),
                 ($urandom_range(15) == 0), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
